// File: rtl/seq_det_pkg.sv
// Shared encodings for the word-level "1010" sequence detector controller
// and its bit-level Mealy detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_REPORT = 2'd2
    } ctrl_state_t;

    // DET_Sk means the last k bits received match the first k bits of PATTERN.
    typedef enum logic [1:0] {
        DET_S0 = 2'd0,
        DET_S1 = 2'd1,
        DET_S2 = 2'd2,
        DET_S3 = 2'd3
    } det_state_t;

    localparam logic [3:0] PATTERN = 4'b1010;

endpackage

// File: rtl/seq1010_mealy.sv
// Overlapping Mealy detector for PATTERN (1010). State advances only when en=1;
// clr returns it to DET_S0 and takes priority over en.
module seq1010_mealy
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic dout
);

    det_state_t state_q;
    det_state_t state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DET_S0;
        end else begin
            state_q <= state_d;
        end
    end

    // A mismatch falls back to the longest suffix that is still a pattern prefix.
    always_comb begin
        state_d = state_q;
        dout    = 1'b0;
        if (clr) begin
            state_d = DET_S0;
        end else if (en) begin
            case (state_q)
                DET_S0: state_d = (din == PATTERN[3]) ? DET_S1 : DET_S0;
                DET_S1: state_d = (din == PATTERN[2]) ? DET_S2 : DET_S1;
                DET_S2: state_d = (din == PATTERN[1]) ? DET_S3 : DET_S0;
                DET_S3: begin
                    if (din == PATTERN[0]) begin
                        state_d = DET_S2;
                        dout    = 1'b1;
                    end else begin
                        state_d = DET_S1;
                    end
                end
                default: state_d = DET_S0;
            endcase
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Word sequencer: accepts a word, shifts it MSB-first through seq1010_mealy,
// reports the per-word match count and keeps a saturating running total.
// Build option: DET_RESTART_PER_WORD_EN clears the detector on every word accept.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1
// and flush is 0; valid and its data hold until that transfer.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int WORD_W  = 8,
    parameter int CNT_W   = 4,
    parameter int TOTAL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WORD_W-1:0]  in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [CNT_W-1:0]   out_count,
    input  logic               out_ready,
    input  logic               flush,
    output logic               busy,
    output logic               match_pulse,
    output logic [TOTAL_W-1:0] total_count
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int SUM_W = TOTAL_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_state_t        state_q;
    ctrl_state_t        state_d;
    logic [WORD_W-1:0]  word_q;
    logic [IDX_W-1:0]   bit_idx_q;
    logic [CNT_W-1:0]   word_cnt_q;
    logic [TOTAL_W-1:0] total_q;
    logic               match_q;

    logic               accept;
    logic               deliver;
    logic               last_bit;
    logic               det_en;
    logic               det_clr;
    logic               det_din;
    logic               det_dout;
    logic [SUM_W-1:0]   total_sum;
    logic [TOTAL_W-1:0] total_next;

    assign accept   = in_valid & in_ready;
    assign deliver  = out_valid & out_ready & ~flush;
    assign last_bit = (bit_idx_q == '0);
    assign det_en   = (state_q == ST_SHIFT) & ~flush;
    assign det_din  = word_q[bit_idx_q];

`ifdef DET_RESTART_PER_WORD_EN
    assign det_clr = flush | accept;
`else
    assign det_clr = flush;
`endif

    seq1010_mealy u_det (
        .clk  (clk),
        .rst  (rst),
        .clr  (det_clr),
        .en   (det_en),
        .din  (det_din),
        .dout (det_dout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (accept)    state_d = ST_SHIFT;
                ST_SHIFT:  if (last_bit)  state_d = ST_REPORT;
                ST_REPORT: if (out_ready) state_d = ST_IDLE;
                default:                  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE) & ~flush;
        out_valid = (state_q == ST_REPORT);
        busy      = (state_q != ST_IDLE);
    end

    // Result is zero-extended into one extra bit so an overflow shows as the carry.
    always_comb begin
        total_sum  = {1'b0, total_q} + SUM_W'(word_cnt_q);
        total_next = total_sum[TOTAL_W] ? '1 : total_sum[TOTAL_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q     <= '0;
            bit_idx_q  <= '0;
            word_cnt_q <= '0;
            total_q    <= '0;
            match_q    <= 1'b0;
        end else begin
            match_q <= det_en & det_dout;
            if (flush) begin
                word_cnt_q <= '0;
            end else if (accept) begin
                word_q     <= in_data;
                bit_idx_q  <= IDX_W'(WORD_W - 1);
                word_cnt_q <= '0;
            end else if (det_en) begin
                if (!last_bit) begin
                    bit_idx_q <= bit_idx_q - IDX_W'(1);
                end
                if (det_dout && (word_cnt_q != CNT_MAX)) begin
                    word_cnt_q <= word_cnt_q + CNT_W'(1);
                end
            end
            if (deliver) begin
                total_q <= total_next;
            end
        end
    end

    assign out_count   = word_cnt_q;
    assign total_count = total_q;
    assign match_pulse = match_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: bit-history reference model with a per-cycle compare
// process, directed word sequences, and a narrow-counter instance for saturation.
module tb_seq_det_ctrl;

    localparam int WORD_W  = 8;
    localparam int CNT_W   = 4;
    localparam int TOTAL_W = 16;
    localparam int PMAX    = 8192;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main DUT ----------------
    logic               in_valid = 1'b0;
    logic [WORD_W-1:0]  in_data  = '0;
    logic               in_ready;
    logic               out_valid;
    logic [CNT_W-1:0]   out_count;
    logic               out_ready = 1'b1;
    logic               flush = 1'b0;
    logic               busy;
    logic               match_pulse;
    logic [TOTAL_W-1:0] total_count;

    seq_det_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W), .TOTAL_W(TOTAL_W)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_count(out_count), .out_ready(out_ready), .flush(flush),
        .busy(busy), .match_pulse(match_pulse), .total_count(total_count)
    );

    // ---------------- saturation DUT ----------------
    logic       s_in_valid = 1'b0;
    logic [7:0] s_in_data  = '0;
    logic       s_in_ready;
    logic       s_out_valid;
    logic [1:0] s_out_count;
    logic       s_out_ready = 1'b1;
    logic       s_flush = 1'b0;
    logic       s_busy;
    logic       s_match_pulse;
    logic [3:0] s_total;

    seq_det_ctrl #(.WORD_W(8), .CNT_W(2), .TOTAL_W(4)) u_sat (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_count(s_out_count), .out_ready(s_out_ready), .flush(s_flush),
        .busy(s_busy), .match_pulse(s_match_pulse), .total_count(s_total)
    );

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    logic [CNT_W-1:0]   exp_q[$];
    int                 rdy_q[$];
    bit                 pulse_exp [0:PMAX-1];
    logic [3:0]         hist = '0;
    int                 hist_len = 0;
    logic [TOTAL_W-1:0] tot_m = '0;

    // Scan the word as a bit stream appended to the history of earlier words.
    task automatic model_accept(input logic [WORD_W-1:0] d);
        int cnt;
        cnt = 0;
`ifdef DET_RESTART_PER_WORD_EN
        hist_len = 0;
`endif
        for (int i = 0; i < WORD_W; i++) begin
            hist = {hist[2:0], d[WORD_W-1-i]};
            hist_len++;
            if (hist_len >= 4 && hist == 4'b1010) begin
                cnt++;
                pulse_exp[(cyc + 2 + i) % PMAX] = 1'b1;
            end
        end
        exp_q.push_back((cnt > 15) ? CNT_W'(15) : CNT_W'(cnt));
        rdy_q.push_back(cyc + WORD_W + 1);
    endtask

    task automatic clear_pulses();
        for (int k = 0; k <= WORD_W + 4; k++) pulse_exp[(cyc + k) % PMAX] = 1'b0;
    endtask

    always @(negedge clk) begin
        bit busy_e, ov_e, ir_e;
        int sum;
        if (rst) begin
            exp_q.delete();
            rdy_q.delete();
            hist_len = 0;
            tot_m    = '0;
            clear_pulses();
        end else begin
            busy_e = (exp_q.size() != 0);
            ov_e   = busy_e && (cyc >= rdy_q[0]);
            ir_e   = !busy_e && !flush;
            chk("match_pulse", match_pulse, pulse_exp[cyc % PMAX]);
            pulse_exp[cyc % PMAX] = 1'b0;
            chk("busy", busy, busy_e);
            chk("out_valid", out_valid, ov_e);
            chk("in_ready", in_ready, ir_e);
            chk("total_count", total_count, tot_m);
            if (ov_e && out_valid) chk("out_count", out_count, exp_q[0]);
            if (flush) begin
                exp_q.delete();
                rdy_q.delete();
                hist_len = 0;
                for (int k = 1; k <= WORD_W + 4; k++) pulse_exp[(cyc + k) % PMAX] = 1'b0;
            end else if (ov_e && out_ready) begin
                sum   = int'(tot_m) + int'(exp_q[0]);
                tot_m = (sum > 65535) ? 16'hFFFF : TOTAL_W'(sum);
                void'(exp_q.pop_front());
                void'(rdy_q.pop_front());
            end else if (ir_e && in_valid) begin
                model_accept(in_data);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [WORD_W-1:0] d);
        bit got;
        got = 0;
        in_data  = d;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (in_ready) got = 1;
        end
        chk("accept_wait", got, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_word(input logic [WORD_W-1:0] d, input int exp_cnt, input string name);
        bit got;
        got = 0;
        out_ready = 1'b1;
        send_word(d);
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (out_valid) got = 1;
        end
        chk({name, "_valid_wait"}, got, 1);
        chk(name, out_count, exp_cnt);
        @(posedge clk);
        #1;
    endtask

    logic [8:0] pat;
    logic [3:0] sat_exp [6] = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd15};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequences ----------------
    initial begin
        #22 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_out_count", out_count, 0);
        chk("reset_total", total_count, 0);

        // 1: 0xAA, latency and pulse timing
        send_word(8'hAA);
        pat = '0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            pat[k-1] = match_pulse;
            if (k == 8) chk("t1_not_yet_valid", out_valid, 0);
            if (k == 9) begin
                chk("t1_valid_c9", out_valid, 1);
                chk("t1_count", out_count, 3);
            end
        end
        chk("t1_pulse_cycles", pat, 9'b101010000);
        @(posedge clk);
        #1 chk("t1_total", total_count, 3);

        // 2: pattern straddling two words
        run_word(8'h05, 0, "t2_w0");
`ifdef DET_RESTART_PER_WORD_EN
        run_word(8'h00, 0, "t2_w1");
        chk("t2_total", total_count, 3);
`else
        run_word(8'h00, 1, "t2_w1");
        chk("t2_total", total_count, 4);
`endif

        // 3: consumer back-pressure
        out_ready = 1'b0;
        send_word(8'hAA);
        repeat (8) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_count", out_count, 3);
            chk("t3_hold_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t3_idle_busy", busy, 0);
        chk("t3_idle_in_ready", in_ready, 1);

        // 4: flush after three bits
        @(posedge clk);
        #1;
        send_word(8'hAA);
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("t4_flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("t4_after_in_ready", in_ready, 1);
        chk("t4_after_busy", busy, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t4_no_valid", out_valid, 0);
        end
        @(posedge clk);
        #1;
        run_word(8'hAA, 3, "t4_next");
`ifdef DET_RESTART_PER_WORD_EN
        chk("t4_total", total_count, 9);
`else
        chk("t4_total", total_count, 10);
`endif

        // 5: asynchronous reset mid-word
        send_word(8'hAA);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_in_ready", in_ready, 1);
        chk("t5_rst_pulse", match_pulse, 0);
        chk("t5_rst_count", out_count, 0);
        chk("t5_rst_total", total_count, 0);
        @(negedge clk);
        @(posedge clk);
        #4 rst = 1'b0;
        @(posedge clk);
        #1;
        run_word(8'hAA, 3, "t5_after");
        chk("t5_total", total_count, 3);

        // extra directed words on the carried detector state
        run_word(8'h55, 2, "x_55");
`ifdef DET_RESTART_PER_WORD_EN
        run_word(8'h50, 1, "x_50");
        run_word(8'hFF, 0, "x_ff");
        chk("x_total", total_count, 6);
`else
        run_word(8'h50, 3, "x_50");
        run_word(8'hFF, 0, "x_ff");
        chk("x_total", total_count, 8);
`endif

        // 6: narrow counters saturate
        for (int w = 0; w < 6; w++) begin
            bit got;
            got = 0;
            s_in_data  = 8'hAA;
            s_in_valid = 1'b1;
            for (int k = 0; k < 50 && !got; k++) begin
                @(negedge clk);
                if (s_in_ready) got = 1;
            end
            chk("t6_accept_wait", got, 1);
            @(posedge clk);
            #1 s_in_valid = 1'b0;
            got = 0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge clk);
                if (s_out_valid) got = 1;
            end
            chk("t6_valid_wait", got, 1);
            chk("t6_count", s_out_count, 3);
            @(posedge clk);
            #1 chk("t6_total", s_total, sat_exp[w]);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
